// File: rtl/video_pixel_feed_if.sv
// Upstream pixel stream into the video feed: valid/ready handshake, 24-bit RGB pixel, start-of-frame flag.
interface video_pixel_feed_if;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic        s_sof;

  modport master (output s_valid, output s_data, output s_sof, input s_ready);
  modport slave  (input s_valid, input s_data, input s_sof, output s_ready);
endinterface

// File: rtl/video_pixel_feed.sv
// Raster timing generator fed from a pixel FIFO that locks each upstream frame (sof) to raster (0,0).
// Optional macro VIDEO_FEED_FILL_PATTERN_EN selects a magenta fill pixel instead of black.
module video_pixel_feed #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  video_pixel_feed_if.slave s,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_start,
  output logic              underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(FIFO_DEPTH);

`ifdef VIDEO_FEED_FILL_PATTERN_EN
  localparam logic [23:0] FILL_PIXEL = 24'hFF00FF;
`else
  localparam logic [23:0] FILL_PIXEL = 24'h000000;
`endif

  typedef enum logic [0:0] {
    ALIGN = 1'b0,
    RUN   = 1'b1
  } state_t;

  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  state_t        state_r;
  state_t        state_next_s;

  logic [24:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_next_s;
  logic          ready_r;

  logic          active_s;
  logic          origin_s;
  logic          hsync_s;
  logic          vsync_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic          show_s;
  logic          uf_s;
  logic [24:0]   head_s;
  logic [23:0]   pix_s;

  assign active_s = (x_r < XW'(H_ACTIVE)) && (y_r < YW'(V_ACTIVE));
  assign origin_s = (x_r == XW'(0)) && (y_r == YW'(0));
  assign hsync_s  = (x_r >= XW'(H_ACTIVE + H_FP)) && (x_r < XW'(H_ACTIVE + H_FP + H_SYNC));
  assign vsync_s  = (y_r >= YW'(V_ACTIVE + V_FP)) && (y_r < YW'(V_ACTIVE + V_FP + V_SYNC));
  assign empty_s  = (count_r == {(AW + 1){1'b0}});
  assign head_s   = mem_r[rd_ptr_r];
  assign push_s   = s.s_valid && ready_r;
  assign s.s_ready = ready_r;

  // Raster position counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r <= XW'(0);
      y_r <= YW'(0);
    end else if (x_r == XW'(H_TOTAL - 1)) begin
      x_r <= XW'(0);
      y_r <= (y_r == YW'(V_TOTAL - 1)) ? YW'(0) : y_r + YW'(1);
    end else begin
      x_r <= x_r + XW'(1);
    end
  end

  // Alignment FSM: decides pop, which pixel to show, and underflow.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    show_s       = 1'b0;
    uf_s         = 1'b0;
    case (state_r)
      ALIGN: begin
        if (empty_s) begin
          pop_s = 1'b0;
        end else if (!head_s[24]) begin
          pop_s = 1'b1;
        end else if (origin_s) begin
          pop_s        = 1'b1;
          show_s       = 1'b1;
          state_next_s = RUN;
        end else begin
          pop_s = 1'b0;
        end
      end
      RUN: begin
        if (!active_s) begin
          pop_s = 1'b0;
        end else if (empty_s) begin
          uf_s         = 1'b1;
          state_next_s = ALIGN;
        end else if (head_s[24] != origin_s) begin
          // sof arriving early, or a missing sof at (0,0): drop lock and realign
          state_next_s = ALIGN;
        end else begin
          pop_s  = 1'b1;
          show_s = 1'b1;
        end
      end
      default: begin
        state_next_s = ALIGN;
      end
    endcase
  end

  // Pixel selection and FIFO occupancy update.
  always_comb begin
    pix_s        = 24'h000000;
    count_next_s = count_r;
    if (!active_s) begin
      pix_s = 24'h000000;
    end else if (show_s) begin
      pix_s = head_s[23:0];
    end else begin
      pix_s = FILL_PIXEL;
    end
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + (AW + 1)'(1);
      2'b01:   count_next_s = count_r - (AW + 1)'(1);
      default: count_next_s = count_r;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ALIGN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FIFO storage; stale contents are harmless because the pointers reset.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wr_ptr_r] <= {s.s_sof, s.s_data};
    end
  end

  // FIFO pointers, occupancy and ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= {(AW + 1){1'b0}};
      ready_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_next_s;
      ready_r <= (count_next_s < DEPTH_L);
    end
  end

  // Registered video outputs, one cycle behind the raster position.
  always_ff @(posedge clk) begin
    if (rst) begin
      red         <= 8'h00;
      green       <= 8'h00;
      blue        <= 8'h00;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      de          <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      red         <= pix_s[23:16];
      green       <= pix_s[15:8];
      blue        <= pix_s[7:0];
      hsync       <= hsync_s;
      vsync       <= vsync_s;
      de          <= active_s;
      frame_start <= origin_s;
      underflow   <= uf_s;
    end
  end

endmodule

// File: tb/tb_video_pixel_feed.sv
// Directed bench for video_pixel_feed on a shrunken 16x8 raster (8x4 active) so whole frames run quickly.
module tb_video_pixel_feed;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3, HT = 16;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1, VT = 8;
  localparam int FR = HT * VT;
`ifdef VIDEO_FEED_FILL_PATTERN_EN
  localparam logic [23:0] FILL = 24'hFF00FF;
`else
  localparam logic [23:0] FILL = 24'h000000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] red, green, blue;
  logic hsync, vsync, de, frame_start, underflow;
  video_pixel_feed_if bus ();

  video_pixel_feed #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst), .s(bus),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .de(de),
    .frame_start(frame_start), .underflow(underflow)
  );

  always #20 clk = ~clk;

  int tests = 0;
  int fails = 0;
  // scenario description: upstream frame lengths, optional stall, and what each displayed frame should show
  int n_feed, stall_f, stall_idx, resume_pos;
  int lens [4];
  int exp_feed [4];
  int exp_lim [4];
  bit exp_uf [4];
  bit chk_full;
  int hs_cnt, vs_cnt, de_cnt, fs_cnt, uf_cnt;

  task automatic run_scenario(input int n_disp);
    int f, idx, pushes, fx, fy, k, ie;
    bit will_push;
    logic e_de, e_hs, e_vs, e_fs, e_uf;
    logic [23:0] e_rgb;
    logic [28:0] act_v, exp_v;
    @(negedge clk);
    rst = 1'b1;
    bus.s_valid = 1'b1; bus.s_sof = 1'b1; bus.s_data = 24'hEE0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({red, green, blue, hsync, vsync, de, frame_start, underflow, bus.s_ready} !== 30'd0) begin
        fails++;
        $display("FAIL reset_outputs cycle %0d: got %h required 0", i,
                 {red, green, blue, hsync, vsync, de, frame_start, underflow, bus.s_ready});
      end
    end
    rst = 1'b0;
    f = 0; idx = 0; pushes = 0; will_push = 1'b0;
    hs_cnt = 0; vs_cnt = 0; de_cnt = 0; fs_cnt = 0; uf_cnt = 0;
    for (int p = -1; p < n_disp * FR; p++) begin
      if (p >= 0) begin
        @(negedge clk);
        if (will_push) begin
          pushes++; idx++;
          if (idx == lens[f]) begin f++; idx = 0; end
        end
        fx = p % HT; fy = (p / HT) % VT; k = p / FR; ie = fy * HA + fx;
        e_de = (fx < HA) && (fy < VA);
        e_hs = (fx >= 10) && (fx < 13);
        e_vs = (fy >= 5) && (fy < 7);
        e_fs = (fx == 0) && (fy == 0);
        e_uf = 1'b0;
        if (!e_de) e_rgb = 24'h000000;
        else if (exp_feed[k] >= 0 && ie < exp_lim[k]) e_rgb = {8'h10 + 8'(exp_feed[k]), 16'(ie)};
        else begin
          e_rgb = FILL;
          e_uf = (exp_feed[k] >= 0) && exp_uf[k] && (ie == exp_lim[k]);
        end
        exp_v = {e_de, e_hs, e_vs, e_fs, e_uf, e_rgb};
        act_v = {de, hsync, vsync, frame_start, underflow, red, green, blue};
        tests++;
        if (act_v !== exp_v) begin
          fails++;
          $display("FAIL pixel p=%0d (x=%0d,y=%0d): got de/hs/vs/fs/uf/rgb=%h required %h", p, fx, fy, act_v, exp_v);
        end
        hs_cnt += int'(hsync); vs_cnt += int'(vsync); de_cnt += int'(de);
        fs_cnt += int'(frame_start); uf_cnt += int'(underflow);
        if (chk_full && (p == 120 || p == 130)) begin
          tests++;
          if ({bus.s_ready, 8'(pushes)} !== ((p == 120) ? {1'b0, 8'd16} : {1'b1, 8'd18})) begin
            fails++;
            $display("FAIL fifo_full p=%0d: got ready=%b pushes=%0d", p, bus.s_ready, pushes);
          end
        end
      end
      if (f >= n_feed || (f == stall_f && idx == stall_idx && p < resume_pos)) begin
        bus.s_valid = 1'b0; bus.s_sof = 1'b0; bus.s_data = 24'h000000;
      end else begin
        bus.s_valid = 1'b1;
        bus.s_sof = (idx == 0);
        bus.s_data = {8'h10 + 8'(f), 16'(idx)};
      end
      will_push = bus.s_valid && bus.s_ready;
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.s_valid = 1'b1; bus.s_sof = 1'b1; bus.s_data = 24'hEE0001;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if ({red, green, blue, hsync, vsync, de, frame_start, underflow, bus.s_ready} !== 30'd0) begin
        fails++;
        $display("FAIL reset_state: got %h required 0",
                 {red, green, blue, hsync, vsync, de, frame_start, underflow, bus.s_ready});
      end
    end
    rst = 1'b0;
    bus.s_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.s_ready, de, frame_start, hsync, vsync, underflow, red, green, blue} !== {6'b111000, FILL}) begin
      fails++;
      $display("FAIL release_first_pixel: got %h required %h",
               {bus.s_ready, de, frame_start, hsync, vsync, underflow, red, green, blue}, {6'b111000, FILL});
    end
    @(negedge clk);
    tests++;
    if ({de, frame_start} !== 2'b10) begin
      fails++;
      $display("FAIL frame_start_single: got de/fs=%b required 10", {de, frame_start});
    end
  endtask

  task automatic test_idle();
    n_feed = 0; stall_f = -1; stall_idx = 0; resume_pos = 0; chk_full = 1'b0;
    lens = '{32, 32, 32, 32};
    exp_feed = '{-1, -1, -1, -1}; exp_lim = '{0, 0, 0, 0}; exp_uf = '{0, 0, 0, 0};
    run_scenario(2);
    tests++;
    if ({hs_cnt, vs_cnt, de_cnt, fs_cnt, uf_cnt} !== {32'd48, 32'd64, 32'd64, 32'd2, 32'd0}) begin
      fails++;
      $display("FAIL idle_totals: got hs=%0d vs=%0d de=%0d fs=%0d uf=%0d required 48 64 64 2 0",
               hs_cnt, vs_cnt, de_cnt, fs_cnt, uf_cnt);
    end
  endtask

  task automatic test_stream();
    n_feed = 4; stall_f = -1; stall_idx = 0; resume_pos = 0; chk_full = 1'b1;
    lens = '{32, 32, 32, 32};
    exp_feed = '{-1, 0, 1, 2}; exp_lim = '{0, 32, 32, 32}; exp_uf = '{0, 0, 0, 0};
    run_scenario(3);
    chk_full = 1'b0;
    tests++;
    if ({fs_cnt, uf_cnt} !== {32'd3, 32'd0}) begin
      fails++;
      $display("FAIL stream_pulses: got fs=%0d uf=%0d required 3 0", fs_cnt, uf_cnt);
    end
  endtask

  task automatic test_underflow();
    n_feed = 4; stall_f = 0; stall_idx = 20; resume_pos = 200; chk_full = 1'b0;
    lens = '{32, 32, 32, 32};
    exp_feed = '{-1, 0, 1, -1}; exp_lim = '{0, 20, 32, 0}; exp_uf = '{0, 1, 0, 0};
    run_scenario(3);
    tests++;
    if (uf_cnt !== 1) begin
      fails++;
      $display("FAIL underflow_once: got %0d pulses required 1", uf_cnt);
    end
  endtask

  task automatic test_early_sof();
    n_feed = 4; stall_f = -1; stall_idx = 0; resume_pos = 0; chk_full = 1'b0;
    lens = '{32, 20, 32, 32};
    exp_feed = '{-1, 0, 1, 2}; exp_lim = '{0, 32, 20, 32}; exp_uf = '{0, 0, 0, 0};
    run_scenario(4);
    tests++;
    if (uf_cnt !== 0) begin
      fails++;
      $display("FAIL early_sof_no_underflow: got %0d pulses required 0", uf_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int pushes;
    bit wp;
    @(negedge clk); rst = 1'b1; bus.s_valid = 1'b0;
    @(negedge clk); rst = 1'b0; pushes = 0;
    for (int c = 0; c < 40; c++) begin
      bus.s_valid = (pushes < 10);
      bus.s_sof = (pushes == 0);
      bus.s_data = {8'hEE, 16'(pushes)};
      wp = bus.s_valid && bus.s_ready;
      @(negedge clk);
      if (wp) pushes++;
    end
    bus.s_valid = 1'b0;
    tests++;
    if (pushes !== 10) begin
      fails++;
      $display("FAIL reset_mid_prefill: got %0d entries required 10", pushes);
    end
    n_feed = 4; stall_f = -1; stall_idx = 0; resume_pos = 0; chk_full = 1'b0;
    lens = '{32, 32, 32, 32};
    exp_feed = '{-1, 0, -1, -1}; exp_lim = '{0, 32, 0, 0}; exp_uf = '{0, 0, 0, 0};
    run_scenario(2);
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.s_sof = 1'b0; bus.s_data = 24'h000000;
    test_reset();
    test_idle();
    test_stream();
    test_underflow();
    test_early_sof();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
